// File: rtl/sys_defs.sv
// Shared bus definitions for the cache/memory interconnect.
package sys_defs;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic {
    OWNER_ICACHE,
    OWNER_DCACHE
  } MEM_OWNER;

endpackage

// File: rtl/mem_tag_table.sv
// Outstanding-load owner table: records which cache owns each memory tag
// and flags returns whose tag has no owner.
module mem_tag_table
  import sys_defs::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       alloc_en,
  input  logic [3:0] alloc_tag,
  input  MEM_OWNER   alloc_owner,
  input  logic [3:0] ret_tag,
  output logic       ret_hit,
  output MEM_OWNER   ret_owner,
  output logic       tag_error
);

  logic [15:0] valid;
  MEM_OWNER    owner [16];

  // Tag 0 means "no return", so entry 0 never matches.
  assign ret_hit   = (ret_tag != 4'd0) && valid[ret_tag];
  assign ret_owner = owner[ret_tag];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid     <= '0;
      tag_error <= 1'b0;
    end else begin
      if (ret_hit)
        valid[ret_tag] <= 1'b0;
      // NOTE: the allocate write comes after the clear, so with non-blocking
      // assignments a same-index clear and allocate leaves the entry valid.
      if (alloc_en)
        valid[alloc_tag] <= 1'b1;
      if ((ret_tag != 4'd0) && !valid[ret_tag])
        tag_error <= 1'b1;
    end
  end

  // NOTE: owner storage is left unreset; the valid bits alone qualify it.
  always_ff @(posedge clock) begin
    if (alloc_en)
      owner[alloc_tag] <= alloc_owner;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory bus between icache and dcache: data side by default,
// icache forced through after STARVE_LIMIT denied cycles; returns steered by tag.
module mem_arbiter
  import sys_defs::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clock,
  input  logic            reset,

  input  BUS_COMMAND      icache2mem_command,
  input  logic [XLEN-1:0] icache2mem_addr,
  output logic [3:0]      mem2icache_response,
  output logic [63:0]     mem2icache_data,
  output logic [3:0]      mem2icache_tag,

  input  BUS_COMMAND      dcache2mem_command,
  input  logic [XLEN-1:0] dcache2mem_addr,
  input  logic [63:0]     dcache2mem_data,
  output logic [3:0]      mem2dcache_response,
  output logic [63:0]     mem2dcache_data,
  output logic [3:0]      mem2dcache_tag,

  output BUS_COMMAND      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,

  output logic            tag_error
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             i_req, d_req, grant_i, grant_d;
  logic             alloc_en, ret_hit;
  MEM_OWNER         ret_owner;

  assign i_req   = (icache2mem_command != BUS_NONE);
  assign d_req   = (dcache2mem_command != BUS_NONE);
  assign grant_i = reset && i_req && (!d_req || (starve_cnt == STARVE_MAX));
  assign grant_d = reset && d_req && !grant_i;

  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    proc2mem_command    = BUS_NONE;
    proc2mem_addr       = '0;
    proc2mem_data       = '0;
    mem2icache_response = 4'd0;
    mem2dcache_response = 4'd0;
    if (grant_i) begin
      proc2mem_command    = icache2mem_command;
      proc2mem_addr       = icache2mem_addr;
      mem2icache_response = mem2proc_response;
    end else if (grant_d) begin
      proc2mem_command    = dcache2mem_command;
      proc2mem_addr       = dcache2mem_addr;
      proc2mem_data       = dcache2mem_data;
      mem2dcache_response = mem2proc_response;
    end
  end

  // Only loads expect a return; stores are fire-and-forget.
  assign alloc_en = (proc2mem_command == BUS_LOAD) && (mem2proc_response != 4'd0);

  mem_tag_table u_tag_table (
    .clock       (clock),
    .reset       (reset),
    .alloc_en    (alloc_en),
    .alloc_tag   (mem2proc_response),
    .alloc_owner (grant_i ? OWNER_ICACHE : OWNER_DCACHE),
    .ret_tag     (mem2proc_tag),
    .ret_hit     (ret_hit),
    .ret_owner   (ret_owner),
    .tag_error   (tag_error)
  );

  always_comb begin
    mem2icache_tag  = 4'd0;
    mem2dcache_tag  = 4'd0;
    mem2icache_data = '0;
    mem2dcache_data = '0;
    if (reset) begin
      mem2icache_data = mem2proc_data;
      mem2dcache_data = mem2proc_data;
      if (ret_hit && (ret_owner == OWNER_ICACHE))
        mem2icache_tag = mem2proc_tag;
      if (ret_hit && (ret_owner == OWNER_DCACHE))
        mem2dcache_tag = mem2proc_tag;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (i_req && !grant_i) begin
      if (starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays both caches and the memory.
module tb_mem_arbiter;
  import sys_defs::*;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  BUS_COMMAND      icache2mem_command, dcache2mem_command, proc2mem_command;
  logic [XLEN-1:0] icache2mem_addr, dcache2mem_addr, proc2mem_addr;
  logic [63:0]     dcache2mem_data, proc2mem_data, mem2proc_data;
  logic [63:0]     mem2icache_data, mem2dcache_data;
  logic [3:0]      mem2icache_response, mem2dcache_response, mem2proc_response;
  logic [3:0]      mem2icache_tag, mem2dcache_tag, mem2proc_tag;
  logic            tag_error;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock               (clock),
    .reset               (reset),
    .icache2mem_command  (icache2mem_command),
    .icache2mem_addr     (icache2mem_addr),
    .mem2icache_response (mem2icache_response),
    .mem2icache_data     (mem2icache_data),
    .mem2icache_tag      (mem2icache_tag),
    .dcache2mem_command  (dcache2mem_command),
    .dcache2mem_addr     (dcache2mem_addr),
    .dcache2mem_data     (dcache2mem_data),
    .mem2dcache_response (mem2dcache_response),
    .mem2dcache_data     (mem2dcache_data),
    .mem2dcache_tag      (mem2dcache_tag),
    .proc2mem_command    (proc2mem_command),
    .proc2mem_addr       (proc2mem_addr),
    .proc2mem_data       (proc2mem_data),
    .mem2proc_response   (mem2proc_response),
    .mem2proc_data       (mem2proc_data),
    .mem2proc_tag        (mem2proc_tag),
    .tag_error           (tag_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change #1 after the rising edge; outputs are checked #1 later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    icache2mem_command = BUS_NONE;
    icache2mem_addr    = '0;
    dcache2mem_command = BUS_NONE;
    dcache2mem_addr    = '0;
    dcache2mem_data    = '0;
    mem2proc_response  = 4'd0;
    mem2proc_tag       = 4'd0;
    mem2proc_data      = '0;
  endtask

  task automatic ret(input logic [3:0] tag, input logic [63:0] data);
    idle();
    mem2proc_tag  = tag;
    mem2proc_data = data;
    #1;
  endtask

  initial begin
    idle();
    // Active stimulus during reset must not leak through.
    dcache2mem_command = BUS_LOAD;
    dcache2mem_addr    = 32'h40;
    mem2proc_response  = 4'd2;
    mem2proc_tag       = 4'd1;
    mem2proc_data      = 64'h1234;
    #2;
    check("rst_cmd",   64'(proc2mem_command), 64'(BUS_NONE));
    check("rst_addr",  64'(proc2mem_addr), 64'h0);
    check("rst_dresp", 64'(mem2dcache_response), 64'h0);
    check("rst_dtag",  64'(mem2dcache_tag), 64'h0);
    check("rst_ddata", mem2dcache_data, 64'h0);
    check("rst_err",   64'(tag_error), 64'h0);
    tick();
    idle();
    reset = 1'b1;
    tick();

    // Icache-only load, tag 3 returned five cycles later.
    icache2mem_command = BUS_LOAD;
    icache2mem_addr    = 32'h100;
    mem2proc_response  = 4'd3;
    #1;
    check("t1_cmd",   64'(proc2mem_command), 64'(BUS_LOAD));
    check("t1_addr",  64'(proc2mem_addr), 64'h100);
    check("t1_iresp", 64'(mem2icache_response), 64'd3);
    check("t1_dresp", 64'(mem2dcache_response), 64'd0);
    tick();
    idle();
    repeat (4) tick();
    ret(4'd3, 64'h1111_2222_3333_4444);
    check("t1_itag",  64'(mem2icache_tag), 64'd3);
    check("t1_dtag",  64'(mem2dcache_tag), 64'd0);
    check("t1_idata", mem2icache_data, 64'h1111_2222_3333_4444);
    tick();

    // Both request every cycle: D,D,D,D,I repeating.
    for (int i = 0; i < 10; i++) begin
      idle();
      icache2mem_command = BUS_LOAD;
      icache2mem_addr    = 32'h1000;
      dcache2mem_command = BUS_LOAD;
      dcache2mem_addr    = 32'h2000;
      mem2proc_response  = 4'd1;
      #1;
      check($sformatf("t2_iresp%0d", i), 64'(mem2icache_response), (i % 5 == 4) ? 64'd1 : 64'd0);
      check($sformatf("t2_dresp%0d", i), 64'(mem2dcache_response), (i % 5 == 4) ? 64'd0 : 64'd1);
      check($sformatf("t2_addr%0d", i),  64'(proc2mem_addr), (i % 5 == 4) ? 64'h1000 : 64'h2000);
      tick();
    end
    ret(4'd1, 64'h5);
    check("t2_itag", 64'(mem2icache_tag), 64'd1);
    check("t2_dtag", 64'(mem2dcache_tag), 64'd0);
    tick();

    // Store is not recorded; tag 7 later belongs to the icache load.
    idle();
    dcache2mem_command = BUS_STORE;
    dcache2mem_addr    = 32'h200;
    dcache2mem_data    = 64'hDEAD_BEEF;
    mem2proc_response  = 4'd7;
    #1;
    check("t3_cmd",   64'(proc2mem_command), 64'(BUS_STORE));
    check("t3_addr",  64'(proc2mem_addr), 64'h200);
    check("t3_data",  proc2mem_data, 64'hDEAD_BEEF);
    check("t3_dresp", 64'(mem2dcache_response), 64'd7);
    tick();
    idle();
    icache2mem_command = BUS_LOAD;
    icache2mem_addr    = 32'h300;
    mem2proc_response  = 4'd7;
    #1;
    check("t3_data0", proc2mem_data, 64'h0);
    tick();
    ret(4'd7, 64'h77);
    check("t3_itag", 64'(mem2icache_tag), 64'd7);
    check("t3_dtag", 64'(mem2dcache_tag), 64'd0);
    tick();

    // Same-cycle clear and reallocation of tag 5.
    idle();
    dcache2mem_command = BUS_LOAD;
    dcache2mem_addr    = 32'h400;
    mem2proc_response  = 4'd5;
    tick();
    idle();
    icache2mem_command = BUS_LOAD;
    icache2mem_addr    = 32'h500;
    mem2proc_response  = 4'd5;
    mem2proc_tag       = 4'd5;
    #1;
    check("t4_dtag",  64'(mem2dcache_tag), 64'd5);
    check("t4_itag",  64'(mem2icache_tag), 64'd0);
    check("t4_iresp", 64'(mem2icache_response), 64'd5);
    tick();
    ret(4'd5, 64'h55);
    check("t4_itag2", 64'(mem2icache_tag), 64'd5);
    check("t4_dtag2", 64'(mem2dcache_tag), 64'd0);
    check("t4_err",   64'(tag_error), 64'd0);
    tick();

    // Unowned tag 9: no steering, sticky error.
    ret(4'd9, 64'h99);
    check("t5_itag", 64'(mem2icache_tag), 64'd0);
    check("t5_dtag", 64'(mem2dcache_tag), 64'd0);
    tick();
    idle();
    check("t5_err", 64'(tag_error), 64'd1);
    repeat (3) tick();
    check("t5_err_hold", 64'(tag_error), 64'd1);

    // Mid-run reset with tags 2, 4, 6 outstanding.
    icache2mem_command = BUS_LOAD;
    icache2mem_addr    = 32'h600;
    mem2proc_response  = 4'd2;
    tick();
    idle();
    dcache2mem_command = BUS_LOAD;
    dcache2mem_addr    = 32'h700;
    mem2proc_response  = 4'd4;
    tick();
    mem2proc_response  = 4'd6;
    tick();
    mem2proc_response  = 4'd8;
    mem2proc_tag       = 4'd2;
    mem2proc_data      = 64'hAAAA;
    reset = 1'b0;
    #1;
    check("t6_cmd",   64'(proc2mem_command), 64'(BUS_NONE));
    check("t6_addr",  64'(proc2mem_addr), 64'h0);
    check("t6_dresp", 64'(mem2dcache_response), 64'd0);
    check("t6_itag",  64'(mem2icache_tag), 64'd0);
    check("t6_idata", mem2icache_data, 64'h0);
    check("t6_err",   64'(tag_error), 64'd0);
    tick();
    idle();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      ret(4'(2 * i + 2), 64'hBAD);
      check($sformatf("t6_stale_i%0d", i), 64'(mem2icache_tag), 64'd0);
      check($sformatf("t6_stale_d%0d", i), 64'(mem2dcache_tag), 64'd0);
      tick();
    end
    idle();
    check("t6_err_set", 64'(tag_error), 64'd1);
    icache2mem_command = BUS_LOAD;
    icache2mem_addr    = 32'h800;
    mem2proc_response  = 4'd3;
    #1;
    check("t6_iresp", 64'(mem2icache_response), 64'd3);
    tick();
    ret(4'd3, 64'h33);
    check("t6_itag_new", 64'(mem2icache_tag), 64'd3);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single memory bus port between the instruction cache miss path and the data cache/LSQ path. It accepts at most one request per cycle and grants the data side by default, with a starvation guard for the instruction side. It records which requester owns each outstanding load tag and steers returned tags and data back to that requester. It sits between `icache`/`dcache` and the memory model, and both caches see it as a plain memory port.

## Interface
- `STARVE_LIMIT`, default 4: consecutive denied icache request cycles after which icache is granted for one cycle.
- `clock` in 1: system clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-low; clears all state immediately when low.
- `icache2mem_command` in 2: BUS_NONE/BUS_LOAD; icache only issues loads.
- `icache2mem_addr` in `XLEN`: 8-byte-aligned line address.
- `mem2icache_response` out 4: tag assigned to the icache request; 0 = not accepted this cycle.
- `mem2icache_data` out 64: returned line data.
- `mem2icache_tag` out 4: tag of the returning data; 0 = none for icache.
- `dcache2mem_command` in 2: BUS_NONE/BUS_LOAD/BUS_STORE.
- `dcache2mem_addr` in `XLEN`, `dcache2mem_data` in 64: address and store data.
- `mem2dcache_response` out 4, `mem2dcache_data` out 64, `mem2dcache_tag` out 4: same meaning as the icache outputs, for the dcache side.
- `proc2mem_command` out 2, `proc2mem_addr` out `XLEN`, `proc2mem_data` out 64: the bus request to memory.
- `mem2proc_response` in 4, `mem2proc_data` in 64, `mem2proc_tag` in 4: memory acceptance tag and returned data/tag.
- `tag_error` out 1: sticky. Set when memory returns a nonzero tag that has no owner.

## Operation
- Grant selection is combinational each cycle:
  - Only one side requests (command != BUS_NONE): that side wins.
  - Both sides request: dcache wins, unless `starve_cnt == STARVE_LIMIT`, in which case icache wins.
- The winner's command, address and data drive `proc2mem_*`. With no request, `proc2mem_command` = BUS_NONE, and address and data = 0.
- `mem2proc_response` goes to the winner's `*_response`. The loser's response is 0, so the loser retries next cycle.
- Owner table: 16 entries of {valid, owner}, entry 0 unused.
  - Written when the granted command is BUS_LOAD and the response is nonzero: entry[response] <= {1, winner}.
  - Stores are not recorded; they are fire-and-forget.
- Return path: when `mem2proc_tag != 0` and entry[tag] is valid:
  - Drive `mem2proc_tag` on the owner's `*_tag` and 0 on the other side's.
  - `mem2proc_data` goes to both data outputs; it is qualified only by the tag.
  - Clear entry[tag] at the clock edge.
- Unowned nonzero tag: both `*_tag` outputs = 0, and `tag_error` is set until reset.
- Same-cycle clear and allocate of the same tag index: the allocation wins, and the entry ends valid with the new owner.
- `starve_cnt` (width `$clog2(STARVE_LIMIT+1)`):
  - Increments, saturating at `STARVE_LIMIT`, when icache requests and is not granted.
  - Resets to 0 when icache is granted or icache does not request.
- Reset low: the owner table is invalidated, `starve_cnt` = 0 and `tag_error` = 0. While reset is low, the forced output values are:
  - `proc2mem_command` = BUS_NONE, and `proc2mem_addr`/`proc2mem_data` = 0;
  - all `*_response` and `*_tag` outputs = 0;
  - `mem2icache_data`/`mem2dcache_data` = 0.
  - Tags returned by memory during or after reset for pre-reset requests are unowned and set `tag_error` once out of reset. This is expected after a mid-run reset; the bench must tolerate it.

## Timing
- Request, grant and response path: zero-cycle combinational pass-through. There is no added latency versus a direct connection.
- Return-tag steering: combinational from `mem2proc_tag` and the registered owner table.
- A tag allocated in cycle N can be returned no earlier than cycle N+1. The table entry is visible from N+1.
- A requester denied in cycle N must hold its command and address. It sees response 0 and re-presents in N+1; the arbiter stores no request.
- Starvation bound: icache waits at most `STARVE_LIMIT` cycles under continuous dcache traffic.

## Structure
- Shared `sys_defs` package:
  - `XLEN`;
  - the bus command encoding BUS_NONE/BUS_LOAD/BUS_STORE;
  - a new `typedef enum logic {OWNER_ICACHE, OWNER_DCACHE} MEM_OWNER`.
- Natural sub-module: `mem_tag_table`. It holds the 16-entry owner table with an allocate port, a lookup/clear port, the collision rule and the unowned-tag detection. The arbitration logic and starvation counter stay in `mem_arbiter`.

## Test plan
- Icache-only load addr 0x100, memory response 3, tag 3 returned 5 cycles later → `mem2icache_response`=3; later `mem2icache_tag`=3 with data; `mem2dcache_tag`=0.
- Both sides load every cycle, STARVE_LIMIT=4 → grants D,D,D,D,I repeating; icache response nonzero exactly every 5th cycle.
- Dcache store addr 0x200 data 0xDEADBEEF, response 7, then icache load gets tag 7 → store not recorded; return of tag 7 goes to icache.
- Tag 5 returning to dcache in the same cycle memory assigns 5 to a new icache load → dcache gets tag 5 that cycle; the next return of 5 goes to icache.
- Memory returns tag 9 with no owner → both `*_tag`=0; `tag_error`=1 and stays 1 until reset.
- Assert reset low mid-run with 3 outstanding tags → outputs drop to reset values immediately; after release, all stale returns route to neither side.
